axi_fmc216_regbank: RTL and testbench
=====================================

# axi_fmc216_regbank

Parametrised AXI4-Lite slave register bank, successor to the fixed four-register FMC216 control slave. It provides NUM_REGS registers, each either read/write or read-only, with byte strobes, decode-error responses and per-register write/read strobes to the FMC216 datapath logic. It sits between the AXI interconnect port and the FMC216 ADC/clock control logic, on the single AXI clock.

## Interface
- NUM_REGS, 4: register count, 2..64.
- DATA_WIDTH, 32: AXI data width, 32 or 64.
- ADDR_WIDTH, 6: byte address width; must be ≥ clog2(NUM_REGS)+clog2(DATA_WIDTH/8).
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from reg_in.
- RESET_VAL, 0: DATA_WIDTH-bit reset value of every RW register.

- ACLK  in  1  single clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel (AWPROT ignored).
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address (ARPROT ignored).
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data.
- reg_out  out  NUM_REGS*DATA_WIDTH  register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]; RO slots output reg_in.
- reg_in  in  NUM_REGS*DATA_WIDTH  status values for RO registers; RW slots ignored.
- wr_pulse  out  NUM_REGS  one-cycle strobe on register i after a successful write.
- rd_pulse  out  NUM_REGS  one-cycle strobe on register i after its read is accepted.
- evt_in  in  DATA_WIDTH  event pulses for sticky register (macro only).
- irq  out  1  OR of sticky register (macro only).

## Operation
- Index = addr[ADDR_WIDTH-1:clog2(DATA_WIDTH/8)]; low byte-lane bits ignored.
- Write: AW and W accepted independently, either order or same cycle; each latched once. AWREADY=1 while no address latched and BVALID=0; WREADY likewise for data.
- Commit when both latched (or handshaking this edge): RW, in range → bytes with WSTRB=1 updated, BRESP=OKAY, wr_pulse[i] high next cycle. Index ≥ NUM_REGS or RO register → no update, no pulse, BRESP=SLVERR (2'b10).
- BVALID held until BREADY; next AW/W not accepted until B handshake completes.
- Read: ARREADY=1 while RVALID=0. On AR handshake RDATA/RRESP registered: in range → current value (reg_in for RO), OKAY, rd_pulse[i] next cycle; out of range → RDATA=0, SLVERR. RDATA/RRESP stable until RREADY.
- Read and write channels independent; read accepted on the same edge as a write commit to the same register returns the old value.

## Timing
- Reset: all RW registers = RESET_VAL; AWREADY=WREADY=ARREADY=0 during reset, 1 first cycle after; BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse=rd_pulse=0, irq=0, latches cleared.
- Write latency: commit edge → BVALID=1 and reg_out updated same edge; wr_pulse asserted the cycle after commit, 1 cycle wide.
- Read latency: AR handshake edge → RVALID=1 that edge (one cycle ARVALID→RVALID).
- Back-to-back: with BREADY/RREADY held 1, one write per 2 cycles, one read per 2 cycles.
- ARESET mid-transaction: pending latches, BVALID, RVALID dropped immediately; no partial write lands.

## Configuration
- AXI_REGBANK_STICKY_EN defined: register NUM_REGS-1 is a sticky event register: bit b set on any cycle evt_in[b]=1, cleared by AXI write of 1 to bit b (W1C, byte strobes honoured); set wins over clear in the same cycle; irq = |register, registered. RO_MASK bit for that register ignored.
- Not defined: register NUM_REGS-1 is an ordinary register per RO_MASK; evt_in ignored; irq tied 0.

## Test plan
- Defaults: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back → same values, all OKAY, wr_pulse[0..3] each once.
- WSTRB=4'b0010 write 0xAABBCCDD to reg 1 holding 0x00000002 → reads 0x0000CC02.
- W before AW by 3 cycles, then AW before W by 3 cycles → both commit once, one BVALID each.
- RO_MASK=4'b0100, reg_in slot 2=0xDEADBEEF: write reg 2 → SLVERR, read → 0xDEADBEEF OKAY; read 0x10 with NUM_REGS=4 → RDATA=0, SLVERR.
- Hold BREADY/RREADY low 5 cycles → BVALID/RVALID/RDATA stable, AWREADY/ARREADY stay 0; ARESET pulse mid-write → reg unchanged at RESET_VAL.
- STICKY_EN: pulse evt_in=0x5 → reg 3=0x5, irq=1; write 0x1 → 0x4; write 0x4 with evt_in[2]=1 same cycle → stays 0x4; write 0x4 → 0, irq=0.

Source files
------------

// File: rtl/axi_fmc216_regbank.sv
// AXI4-Lite register bank for the FMC216 control path: NUM_REGS RW/RO registers with
// byte strobes, decode errors and per-register strobes. Optional macro: AXI_REGBANK_STICKY_EN.
module axi_fmc216_regbank #(
    parameter int                    NUM_REGS   = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse,
    input  logic [DATA_WIDTH-1:0]          evt_in,
    output logic                           irq
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - LSB;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_REGBANK_STICKY_EN
    // The sticky register is always AXI-writable (W1C), whatever RO_MASK says.
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~(NUM_REGS'(1) << (NUM_REGS - 1));
`else
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`endif

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs, regs_nxt, reg_val;
    logic                  aw_lat, w_lat;
    logic [ADDR_WIDTH-1:0] aw_addr_q, wa;
    logic [DATA_WIDTH-1:0] w_data_q, wd, wmask, rd_val;
    logic [NB-1:0]         w_strb_q, ws;
    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_in;
    logic [NUM_REGS-1:0]   w_sel, r_sel;
    logic                  unused_bits;

    assign S_AXI_AWREADY = !ARESET && !aw_lat && !S_AXI_BVALID;
    assign S_AXI_WREADY  = !ARESET && !w_lat && !S_AXI_BVALID;
    assign S_AXI_ARREADY = !ARESET && !S_AXI_RVALID;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (aw_lat || aw_hs) && (w_lat || w_hs);

    // A latched beat takes priority; otherwise the one handshaking this edge is used.
    assign wa = aw_lat ? aw_addr_q : S_AXI_AWADDR;
    assign wd = w_lat ? w_data_q : S_AXI_WDATA;
    assign ws = w_lat ? w_strb_q : S_AXI_WSTRB;

    always_comb begin
        w_sel  = '0;
        r_sel  = '0;
        rd_val = '0;
        wmask  = '0;
        for (int b = 0; b < NB; b++)
            wmask[b*8 +: 8] = {8{ws[b]}};
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_val[i] = RO_EFF[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            w_sel[i]   = (wa[ADDR_WIDTH-1:LSB] == IW'(i));
            r_sel[i]   = (S_AXI_ARADDR[ADDR_WIDTH-1:LSB] == IW'(i));
            if (r_sel[i])
                rd_val = reg_val[i];
        end
    end

    assign wr_ok   = |(w_sel & ~RO_EFF);
    assign rd_in   = |r_sel;
    assign reg_out = reg_val;

    always_comb begin
        regs_nxt = regs;
        for (int i = 0; i < NUM_REGS; i++)
            if (commit && w_sel[i] && !RO_EFF[i])
                regs_nxt[i] = (regs[i] & ~wmask) | (wd & wmask);
`ifdef AXI_REGBANK_STICKY_EN
        // W1C on strobed bytes, then new events OR in so a same-cycle set wins.
        regs_nxt[NUM_REGS-1] = (regs[NUM_REGS-1] & ~((commit && w_sel[NUM_REGS-1]) ? (wd & wmask) : '0))
                               | evt_in;
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs <= {NUM_REGS{RESET_VAL}};
`ifdef AXI_REGBANK_STICKY_EN
            regs[NUM_REGS-1] <= '0;
`endif
            aw_lat       <= 1'b0;
            w_lat        <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= OKAY;
            S_AXI_RDATA  <= '0;
            wr_pulse     <= '0;
            rd_pulse     <= '0;
        end else begin
            regs     <= regs_nxt;
            wr_pulse <= commit ? (w_sel & ~RO_EFF) : '0;
            rd_pulse <= ar_hs ? r_sel : '0;

            if (S_AXI_BVALID && S_AXI_BREADY)
                S_AXI_BVALID <= 1'b0;
            if (commit) begin
                aw_lat       <= 1'b0;
                w_lat        <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_ok ? OKAY : SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_lat    <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_lat    <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end

            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_in ? rd_val : '0;
                S_AXI_RRESP  <= rd_in ? OKAY : SLVERR;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

`ifdef AXI_REGBANK_STICKY_EN
    // Taken from the next register value so irq tracks the register cycle-for-cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) irq <= 1'b0;
        else        irq <= |regs_nxt[NUM_REGS-1];
    end
    assign unused_bits = ^{wa[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};
`else
    assign irq = 1'b0;
    assign unused_bits = ^{wa[LSB-1:0], S_AXI_ARADDR[LSB-1:0], evt_in};
`endif

endmodule

// File: tb/tb_axi_fmc216_regbank.sv
// Scoreboard bench for axi_fmc216_regbank: directed cases plus randomized traffic checked
// against an array-based register model; honours AXI_REGBANK_STICKY_EN.
module tb_axi_fmc216_regbank;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NB = DW / 8;
    localparam logic [NR-1:0] RO = 4'b0100;
    localparam logic [DW-1:0] RV = 32'h1357_9BDF;
`ifdef AXI_REGBANK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             ACLK = 1'b0, ARESET = 1'b1;
    logic [AW-1:0]    S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic             S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic             S_AXI_BREADY = 1'b1, S_AXI_RREADY = 1'b1;
    logic [DW-1:0]    S_AXI_WDATA = '0;
    logic [NB-1:0]    S_AXI_WSTRB = '0;
    logic             S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID;
    logic [1:0]       S_AXI_BRESP, S_AXI_RRESP;
    logic [DW-1:0]    S_AXI_RDATA;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] reg_in = '0;
    logic [NR-1:0]    wr_pulse, rd_pulse;
    logic [DW-1:0]    evt_in = '0;
    logic             irq;

    axi_fmc216_regbank #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                         .RO_MASK(RO), .RESET_VAL(RV)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse),
        .evt_in(evt_in), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; } rsp_t;
    rsp_t          bq[$], rq[$];
    logic [DW-1:0] m_regs [NR];
    int            exp_wp [NR], exp_rp [NR], got_wp [NR], got_rp [NR];
    int            total = 0, passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic bit is_ro(input int i);
        return RO[i] && !(STICKY && i == NR - 1);
    endfunction

    function automatic logic [DW-1:0] cur(input int i);
        return is_ro(i) ? reg_in[i*DW +: DW] : m_regs[i];
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = cur(i);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = (STICKY && i == NR - 1) ? '0 : RV;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
        int idx = int'(a) / NB;
        if (idx >= NR || is_ro(idx)) begin
            bq.push_back('{data: '0, resp: 2'b10});
        end else begin
            for (int b = 0; b < NB; b++)
                if (s[b]) begin
                    if (STICKY && idx == NR - 1) m_regs[idx][b*8 +: 8] &= ~d[b*8 +: 8];
                    else                         m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
                end
            bq.push_back('{data: '0, resp: 2'b00});
            exp_wp[idx]++;
        end
    endtask

    task automatic model_read(input logic [AW-1:0] a);
        int idx = int'(a) / NB;
        if (idx >= NR) rq.push_back('{data: '0, resp: 2'b10});
        else begin
            rq.push_back('{data: cur(idx), resp: 2'b00});
            exp_rp[idx]++;
        end
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return S_AXI_AWREADY;
            1:       return S_AXI_WREADY;
            2:       return S_AXI_ARREADY;
            3:       return S_AXI_BVALID && S_AXI_BREADY;
            default: return S_AXI_RVALID && S_AXI_RREADY;
        endcase
    endfunction

    // Bounded wait for a condition seen mid-cycle; returns just after the edge that consumes it.
    task automatic wait_sig(input int which, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge ACLK);
            ok = sig(which);
        end
        if (!ok) begin
            total++;
            $display("FAIL %s_timeout: got no handshake, expected one within 50 cycles", name);
        end
        step();
    endtask

    task automatic bus_aw(input logic [AW-1:0] a, input int dly);
        repeat (dly) step();
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        wait_sig(0, "aw");
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic bus_w(input logic [DW-1:0] d, input logic [NB-1:0] s, input int dly);
        repeat (dly) step();
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        wait_sig(1, "w");
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s,
                               input int awd, input int wdl);
        model_write(a, d, s);
        fork
            bus_aw(a, awd);
            bus_w(d, s, wdl);
        join
        chk("b_latency", S_AXI_BVALID, 1'b1);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s,
                         input int awd, input int wdl);
        issue_write(a, d, s, awd, wdl);
        wait_sig(3, "b");
        chk("reg_out", reg_out, model_flat());
    endtask

    task automatic bus_read(input logic [AW-1:0] a);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        wait_sig(2, "ar");
        S_AXI_ARVALID = 1'b0;
        chk("r_latency", S_AXI_RVALID, 1'b1);
    endtask

    task automatic read(input logic [AW-1:0] a);
        model_read(a);
        bus_read(a);
        wait_sig(4, "r");
    endtask

    // Scoreboard monitor: pops on every completed response handshake.
    always @(negedge ACLK) begin
        rsp_t e;
        if (!ARESET) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (bq.size() == 0) begin
                    total++;
                    $display("FAIL b_unexpected: got BRESP 0x%0h, expected no response", S_AXI_BRESP);
                end else begin
                    e = bq.pop_front();
                    chk("bresp", S_AXI_BRESP, e.resp);
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (rq.size() == 0) begin
                    total++;
                    $display("FAIL r_unexpected: got RDATA 0x%0h, expected no response", S_AXI_RDATA);
                end else begin
                    e = rq.pop_front();
                    chk("rresp", S_AXI_RRESP, e.resp);
                    chk("rdata", S_AXI_RDATA, e.data);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (wr_pulse[i]) got_wp[i]++;
                if (rd_pulse[i]) got_rp[i]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rexp;
        logic [1:0]    bexp;
        for (int i = 0; i < NR; i++) begin
            exp_wp[i] = 0; exp_rp[i] = 0; got_wp[i] = 0; got_rp[i] = 0;
        end
        model_reset();
        reg_in[2*DW +: DW] = 32'hDEAD_BEEF;

        // Reset state
        repeat (3) step();
        @(negedge ACLK);
        chk("rst_awready", S_AXI_AWREADY, 1'b0);
        chk("rst_wready", S_AXI_WREADY, 1'b0);
        chk("rst_arready", S_AXI_ARREADY, 1'b0);
        step();
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        chk("post_rst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 6'b0);
        chk("post_rst_rdata", S_AXI_RDATA, 32'h0);
        chk("post_rst_reg_out", reg_out, model_flat());
        chk("post_rst_pulses_irq", {wr_pulse, rd_pulse, irq}, 9'b0);
        step();

        // Basic write / read-back, including the RO slot
        for (int i = 0; i < NR; i++) write(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < NR; i++) read(AW'(i * 4));

        // Byte strobes: only byte 1 lands
        write(6'h04, 32'hAABB_CCDD, 4'b0010, 0, 0);
        chk("strobe_reg1", reg_out[DW +: DW], 32'h0000_CC02);
        read(6'h04);

        // Channel ordering: W leads by 3, then AW leads by 3
        write(6'h00, 32'h0000_0011, 4'hF, 3, 0);
        write(6'h00, 32'h0000_0022, 4'hF, 0, 3);
        read(6'h00);

        // Decode errors
        read(6'h10);
        read(6'h3F);
        write(6'h2C, 32'hFFFF_FFFF, 4'hF, 1, 0);

        // Backpressure on B
        S_AXI_BREADY = 1'b0;
        issue_write(6'h04, 32'h0000_0055, 4'hF, 0, 0);
        bexp = bq[0].resp;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("bstall_valid", S_AXI_BVALID, 1'b1);
            chk("bstall_resp", S_AXI_BRESP, bexp);
            chk("bstall_readys", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
        end
        step();
        S_AXI_BREADY = 1'b1;
        wait_sig(3, "b");

        // Backpressure on R; the status input moves while the response is held
        S_AXI_RREADY = 1'b0;
        rexp = reg_in[2*DW +: DW];
        model_read(6'h08);
        bus_read(6'h08);
        reg_in[2*DW +: DW] = 32'h0BAD_F00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("rstall_valid", S_AXI_RVALID, 1'b1);
            chk("rstall_data", S_AXI_RDATA, rexp);
            chk("rstall_arready", S_AXI_ARREADY, 1'b0);
        end
        step();
        S_AXI_RREADY = 1'b1;
        wait_sig(4, "r");

        // Read and write of the same register on the same edge: read sees the old value
        model_read(6'h04);
        model_write(6'h04, 32'h7777_8888, 4'hF);
        S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h7777_8888; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("same_edge_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        fork
            wait_sig(3, "b");
            wait_sig(4, "r");
        join
        chk("same_edge_reg_out", reg_out, model_flat());

        // Reset in the middle of a write: AW latched, W never arrives
        bus_aw(6'h00, 0);
        ARESET = 1'b1;
        model_reset();
        @(negedge ACLK);
        chk("midrst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY}, 3'b000);
        step();
        ARESET = 1'b0;
        step();
        chk("midrst_reg_out", reg_out, model_flat());
        write(6'h04, 32'h0000_ABCD, 4'hF, 0, 2);
        read(6'h00);
        read(6'h04);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            reg_in = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0)
                write(AW'($urandom_range(0, 63)), $urandom, NB'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            else
                read(AW'($urandom_range(0, 63)));
        end

`ifdef AXI_REGBANK_STICKY_EN
        // Sticky event register
        evt_in = 32'h5;
        step();
        evt_in = '0;
        m_regs[NR-1] |= 32'h5;
        @(negedge ACLK);
        chk("sticky_set", reg_out[(NR-1)*DW +: DW], m_regs[NR-1]);
        chk("sticky_irq_on", irq, 1'b1);
        step();
        write(6'h0C, 32'h1, 4'hF, 0, 0);
        evt_in = 32'h4;
        model_write(6'h0C, 32'h4, 4'hF);
        m_regs[NR-1] |= 32'h4;
        fork
            bus_aw(6'h0C, 0);
            bus_w(32'h4, 4'hF, 0);
        join
        wait_sig(3, "b");
        evt_in = '0;
        chk("sticky_set_wins", reg_out[(NR-1)*DW +: DW], 32'h4);
        write(6'h0C, 32'h4, 4'hF, 0, 0);
        chk("sticky_cleared", reg_out[(NR-1)*DW +: DW], 32'h0);
        @(negedge ACLK);
        chk("sticky_irq_off", irq, 1'b0);
        step();
`endif

        repeat (3) step();
        chk("bq_drained", bq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("wr_pulse_cnt%0d", i), got_wp[i], exp_wp[i]);
            chk($sformatf("rd_pulse_cnt%0d", i), got_rp[i], exp_rp[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
